// File: rtl/commit_trace_buffer.sv
// Commit-stream trace buffer: filters register/memory commit events and queues
// them as records in a FIFO that is drained over a valid/ready port.
module commit_trace_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [ADDR_W-1:0]                     pc,
    input  logic                                  reg_write,
    input  logic [REG_AW-1:0]                     rd,
    input  logic [DATA_W-1:0]                     rd_data,
    input  logic                                  mem_read,
    input  logic                                  mem_write,
    input  logic [DATA_W-1:0]                     mem_rdata,
    input  logic [DATA_W-1:0]                     mem_wdata,
    input  logic [2:0]                            chan_en,
    input  logic                                  wrap_mode,
    input  logic                                  start,
    input  logic                                  stop,
    input  logic                                  clear,
    input  logic [ADDR_W-1:0]                     stop_pc,
    input  logic                                  stop_pc_en,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [3+REG_AW+ADDR_W+2*DATA_W-1:0]   out_rec,
    output logic [$clog2(DEPTH):0]                count,
    output logic                                  overflow,
    output logic [CNT_W-1:0]                      drop_cnt,
    output logic [1:0]                            state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int REC_W = 3 + REG_AW + ADDR_W + 2 * DATA_W;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FROZEN = 2'b10
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [REC_W-1:0]       mem_r [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]          count_r, count_nxt_s;
    logic                   out_valid_r;
    logic                   overflow_r;
    logic [CNT_W-1:0]       drop_cnt_r;

    logic [2:0]             flags_s;
    logic [DATA_W-1:0]      mem_data_s;
    logic [REC_W-1:0]       rec_s;
    logic                   push_s, pop_s, full_s;
    logic                   wr_en_s, drop_s, rd_adv_s;

    // Event filtering, record assembly and FIFO control decisions.
    always_comb begin
        flags_s     = {mem_write, mem_read, reg_write && (rd != {REG_AW{1'b0}})} & chan_en;
        mem_data_s  = {DATA_W{1'b0}};
        if (flags_s[1]) begin
            mem_data_s = mem_rdata;
        end else if (flags_s[2]) begin
            mem_data_s = mem_wdata;
        end else begin
            mem_data_s = {DATA_W{1'b0}};
        end
        rec_s = {flags_s,
                 flags_s[0] ? rd : {REG_AW{1'b0}},
                 pc,
                 flags_s[0] ? rd_data : {DATA_W{1'b0}},
                 mem_data_s};
        push_s   = (state_r == ST_RUN) && (flags_s != 3'b000) && !stop;
        full_s   = (count_r == FULL_CNT);
        pop_s    = out_valid_r && out_ready;
        // A full FIFO still accepts when a pop frees the slot or when overwriting.
        wr_en_s  = push_s && (!full_s || pop_s || wrap_mode);
        drop_s   = push_s && full_s && !pop_s;
        rd_adv_s = pop_s || (drop_s && wrap_mode);
        count_nxt_s = count_r;
        if (wr_en_s && !rd_adv_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (!wr_en_s && rd_adv_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Recording-control state transitions; stop beats start.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_FROZEN: begin
                if (start && !stop) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                if (stop || (stop_pc_en && (pc == stop_pc))) begin
                    state_nxt_s = ST_FROZEN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pointers, occupancy and drop bookkeeping; clear overrides push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CW{1'b0}};
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            drop_cnt_r  <= {CNT_W{1'b0}};
        end else if (clear) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CW{1'b0}};
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            drop_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_adv_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != {CW{1'b0}});
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != {CNT_W{1'b1}}) begin
                    drop_cnt_r <= drop_cnt_r + CNT_W'(1);
                end
            end
        end
    end

    // Record storage carries no reset; only occupancy marks slots as valid.
    always_ff @(posedge clk) begin
        if (wr_en_s && !clear) begin
            mem_r[wr_ptr_r] <= rec_s;
        end
    end

    assign out_rec   = mem_r[rd_ptr_r];
    assign out_valid = out_valid_r;
    assign count     = count_r;
    assign overflow  = overflow_r;
    assign drop_cnt  = drop_cnt_r;
    assign state     = state_r;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: a queue-based reference model
// predicts the FIFO contents; a negedge monitor compares every drained record.
module tb_commit_trace_buffer;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;
    localparam int REC_W  = 3 + REG_AW + ADDR_W + 2 * DATA_W;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [ADDR_W-1:0] pc = '0, stop_pc = '0;
    logic reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic [REG_AW-1:0] rd = '0;
    logic [DATA_W-1:0] rd_data = '0, mem_rdata = '0, mem_wdata = '0;
    logic [2:0] chan_en = 3'b111;
    logic wrap_mode = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic stop_pc_en = 1'b0, out_ready = 1'b0;
    logic out_valid, overflow;
    logic [REC_W-1:0] out_rec;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_W-1:0] drop_cnt;
    logic [1:0] state;

    commit_trace_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_AW(REG_AW),
                          .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .reg_write(reg_write), .rd(rd),
        .rd_data(rd_data), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .chan_en(chan_en),
        .wrap_mode(wrap_mode), .start(start), .stop(stop), .clear(clear),
        .stop_pc(stop_pc), .stop_pc_en(stop_pc_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_rec(out_rec), .count(count),
        .overflow(overflow), .drop_cnt(drop_cnt), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: expected FIFO contents oldest-first, plus status.
    logic [REC_W-1:0]  mq[$];
    logic [DATA_W-1:0] drained[$];
    logic [1:0]        m_state = 2'b00;
    logic              m_ovf = 1'b0;
    int                m_drop = 0;
    bit                popped = 1'b0;
    int                n_vec = 0;
    int                n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [REC_W-1:0] exp_rec();
        logic rw, mr, mw;
        logic [DATA_W-1:0] md;
        rw = reg_write && chan_en[0] && (rd != '0);
        mr = mem_read && chan_en[1];
        mw = mem_write && chan_en[2];
        md = mr ? mem_rdata : (mw ? mem_wdata : '0);
        return {mw, mr, rw, rw ? rd : {REG_AW{1'b0}}, pc, rw ? rd_data : {DATA_W{1'b0}}, md};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_state = 2'b00;
        m_ovf = 1'b0;
        m_drop = 0;
    endtask

    // Applies the rules for the edge that just occurred, using the inputs held over it.
    task automatic model_step();
        logic [REC_W-1:0] r;
        bit ev, push;
        int occ;
        if (!rst_n) begin
            model_reset();
            return;
        end
        r = exp_rec();
        ev = (r[REC_W-1 -: 3] != 3'b000);
        push = (m_state == 2'b01) && ev && !stop;
        if (clear) begin
            mq.delete();
            m_ovf = 1'b0;
            m_drop = 0;
        end else if (push) begin
            occ = mq.size() + (popped ? 1 : 0);
            if (occ < DEPTH || popped) begin
                mq.push_back(r);
            end else begin
                if (wrap_mode) begin
                    void'(mq.pop_front());
                    mq.push_back(r);
                end
                m_ovf = 1'b1;
                if (m_drop < (1 << CNT_W) - 1) m_drop++;
            end
        end
        if (m_state == 2'b01) begin
            if (stop || (stop_pc_en && pc == stop_pc)) m_state = 2'b10;
        end else if (start && !stop) begin
            m_state = 2'b01;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        popped = 1'b0;
        #1;
    endtask

    // Monitor: status against the model, and every accepted record against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", count, mq.size());
            chk("out_valid", out_valid, mq.size() != 0);
            chk("overflow", overflow, m_ovf);
            chk("drop_cnt", drop_cnt, m_drop);
            chk("state", state, m_state);
            if (mq.size() != 0 && out_ready && !clear) begin
                chk("out_rec", out_rec, mq[0]);
                drained.push_back(out_rec[2*DATA_W-1:DATA_W]);
                void'(mq.pop_front());
                popped = 1'b1;
            end
        end
    end

    task automatic fill(input int n, input bit wrap);
        wrap_mode = wrap; chan_en = 3'b001; reg_write = 1'b1; rd = 5'd5;
        for (int i = 1; i <= n; i++) begin
            rd_data = i; pc = i * 4;
            tick();
        end
        reg_write = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    initial begin
        logic [REC_W-1:0] lw_rec;
        // Reset values, asserted asynchronously before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_state", state, 2'b00);
        chk("rst_drop", drop_cnt, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // lw at 0x4 with both register and read channels.
        start = 1'b1; tick(); start = 1'b0;
        chk("run_state", state, 2'b01);
        pc = 32'h4; reg_write = 1'b1; rd = 5'd8; rd_data = 32'd7; mem_read = 1'b1; mem_rdata = 32'd7;
        tick();
        reg_write = 1'b0; mem_read = 1'b0;
        lw_rec = {3'b011, 5'd8, 32'h4, 32'd7, 32'd7};
        chk("lw_rec", out_rec, lw_rec);
        chk("lw_valid", out_valid, 1);
        chk("lw_count", count, 1);

        // sw at 0x8: masked out, then captured with the write channel enabled.
        pc = 32'h8; mem_write = 1'b1; mem_wdata = 32'h55; chan_en = 3'b011;
        tick();
        chk("sw_masked", count, 1);
        chan_en = 3'b111;
        tick();
        mem_write = 1'b0;
        chk("sw_count", count, 2);
        out_ready = 1'b1; repeat (3) tick(); out_ready = 1'b0;

        // Stop-when-full: first 16 kept, last 4 dropped.
        do_clear();
        fill(20, 1'b0);
        chk("nowrap_count", count, 16);
        chk("nowrap_ovf", overflow, 1);
        chk("nowrap_drop", drop_cnt, 4);
        drained.delete();
        out_ready = 1'b1; repeat (17) tick(); out_ready = 1'b0;
        chk("nowrap_n", drained.size(), 16);
        chk("nowrap_first", drained[0], 1);
        chk("nowrap_last", drained[15], 16);

        // Wrap: oldest 4 overwritten.
        do_clear();
        fill(20, 1'b1);
        chk("wrap_count", count, 16);
        chk("wrap_drop", drop_cnt, 4);
        drained.delete();
        out_ready = 1'b1; repeat (17) tick(); out_ready = 1'b0;
        chk("wrap_n", drained.size(), 16);
        chk("wrap_first", drained[0], 5);
        chk("wrap_last", drained[15], 20);

        // stop_pc freeze records the matching commit, then start resumes.
        do_clear();
        wrap_mode = 1'b0; stop_pc_en = 1'b1; stop_pc = 32'h10;
        reg_write = 1'b1; rd = 5'd3; chan_en = 3'b001;
        pc = 32'hC; tick();
        pc = 32'h10; tick();
        chk("frozen", state, 2'b10);
        pc = 32'h14; tick();
        reg_write = 1'b0; stop_pc_en = 1'b0;
        chk("frozen_count", count, 2);
        start = 1'b1; tick(); start = 1'b0;
        chk("resume_state", state, 2'b01);
        chk("resume_count", count, 2);

        // Push, pop and clear together on a full FIFO.
        do_clear();
        fill(16, 1'b0);
        chk("full_count", count, 16);
        reg_write = 1'b1; out_ready = 1'b1; clear = 1'b1;
        tick();
        reg_write = 1'b0; out_ready = 1'b0; clear = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_valid", out_valid, 0);

        // Asynchronous reset in the middle of a stream.
        fill(5, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_state", state, 2'b00);
        chk("mid_rst_ovf", overflow, 0);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            pc         = {$urandom_range(0, 15), 2'b00};
            reg_write  = $urandom_range(0, 1);
            rd         = $urandom_range(0, 31);
            rd_data    = $urandom;
            mem_read   = ($urandom_range(0, 3) == 0);
            mem_write  = ($urandom_range(0, 3) == 0);
            mem_rdata  = $urandom;
            mem_wdata  = $urandom;
            chan_en    = $urandom_range(0, 7);
            if ($urandom_range(0, 15) == 0) wrap_mode = ~wrap_mode;
            start      = ($urandom_range(0, 7) == 0);
            stop       = ($urandom_range(0, 19) == 0);
            clear      = ($urandom_range(0, 79) == 0);
            stop_pc_en = ($urandom_range(0, 3) == 0);
            stop_pc    = {$urandom_range(0, 15), 2'b00};
            out_ready  = ($urandom_range(0, 2) == 0);
            tick();
        end
        start = 1'b0; stop = 1'b0; clear = 1'b0; reg_write = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; out_ready = 1'b1;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
